pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipeline_stage_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
//   One valid/ready pipeline register stage. All state changes on the
//   falling edge of clk. Reset is synchronous and active-high.
//
//   Build option: define PIPE_STAGE_SKID_EN for two-entry skid mode.
//     - Defined: main + skid registers. in_ready depends only on
//       registered state, so there is no combinational out_ready -> in_ready
//       path.
//     - Undefined: single entry. in_ready follows out_ready when the entry
//       is live.
//
// Ports
//   clk, rst          clock (falling-edge active) and sync active-high reset
//   flush             squash every held entry; blocks input this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   occupancy         entries held (0..2), registered
//   stall_count       saturating count of back-pressured upstream cycles
module pipeline_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic              in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_nxt;
    assign in_ready = (state != FULL) && !flush && !rst;
`else
    assign in_ready = (!out_valid || out_ready) && !flush && !rst;
`endif

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Next state and payload routing. A flush drops everything, but main_q
    // keeps its old contents so out_data holds its last value.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_nxt  = skid_q;
`endif
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_nxt = in_data;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        // Main is still held downstream; park the new beat.
                        state_nxt = FULL;
                        skid_nxt  = in_data;
`endif
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (out_xfer) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            occupancy <= 2'd0;
            main_q    <= '0;
        end else begin
            state     <= state_nxt;
            occupancy <= 2'(state_nxt);
            main_q    <= main_nxt;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(negedge clk) begin
        if (rst) skid_q <= '0;
        else     skid_q <= skid_nxt;
    end
`endif

    // Counts refused offers, including those blocked by flush.
    always_ff @(negedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (in_valid && !in_ready && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg. A queue-based reference model tracks the
// held entries; it follows either buffering mode via PIPE_STAGE_SKID_EN.
module tb_pipeline_stage_reg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_count;

    pipeline_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int                n_chk = 0, n_bad = 0;
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] shown = '0;
    int                exp_stall = 0;
    logic              seen_ready;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One clock: drive at posedge, check in_ready mid-cycle, advance the
    // model, check registered outputs just after the falling edge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [DATA_W-1:0] d, input logic ordy);
        logic rdy, ox, ix;
        @(posedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        rdy = (q.size() < CAP) && !f && !r;
`else
        rdy = (q.size() == 0 || ordy) && !f && !r;
`endif
        seen_ready = in_ready;
        chk("in_ready", in_ready, rdy);
        ox = (q.size() > 0) && ordy;
        ix = iv && rdy;
        if (r) begin
            q.delete(); shown = '0; exp_stall = 0;
        end else begin
            if (iv && !rdy && exp_stall < MAXC) exp_stall++;
            if (ox) void'(q.pop_front());
            if (f) q.delete();
            else begin
                if (ix) q.push_back(d);
                if (q.size() > 0) shown = q[0];
            end
        end
        @(negedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("occupancy", occupancy, q.size());
        chk("out_data", out_data, shown);
        chk("stall_count", stall_count, exp_stall);
    endtask

    initial begin
        // reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 16'h1234, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);

        // single beat latency and hold-after-drain
        cyc(0, 0, 1, 16'h00A5, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 16'h00A5);
        chk("lat_occ", occupancy, 1);
        cyc(0, 0, 0, 0, 1);
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", out_data, 16'h00A5);

`ifdef PIPE_STAGE_SKID_EN
        // skid fill, stall counting, ordered drain
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0011, 0);
        cyc(0, 0, 1, 16'h0022, 0);
        chk("skid_occ", occupancy, 2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h0033, 0);
        chk("skid_ready", seen_ready, 0);
        chk("skid_stall", stall_count, 3);
        chk("skid_head", out_data, 16'h0011);
        cyc(0, 0, 1, 16'h0033, 1);
        chk("skid_ord1", out_data, 16'h0022);
        cyc(0, 0, 1, 16'h0033, 1);
        chk("skid_ord2", out_data, 16'h0033);
        cyc(0, 0, 0, 0, 1);
`else
        // single-entry back-pressure and same-edge replace
        cyc(0, 0, 1, 16'h0044, 0);
        cyc(0, 0, 1, 16'h0055, 0);
        chk("one_ready", seen_ready, 0);
        cyc(0, 0, 1, 16'h0055, 1);
        chk("one_ready2", seen_ready, 1);
        chk("one_valid", out_valid, 1);
        chk("one_repl", out_data, 16'h0055);
        cyc(0, 0, 0, 0, 1);
`endif

        // flush with full stage and an offered input
        for (int i = 0; i < CAP; i++) cyc(0, 0, 1, 16'(16'h0100 + i), 0);
        chk("pre_flush_occ", occupancy, CAP);
        cyc(0, 1, 1, 16'h0BAD, 0);
        chk("flush_ready", seen_ready, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);
        cyc(0, 0, 0, 0, 1);
        chk("flush_nocap", out_valid, 0);

        // counter saturation, then reset together with flush
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < CAP + 20; i++) cyc(0, 0, 1, 16'h0777, 0);
        chk("sat", stall_count, MAXC);
        cyc(1, 1, 1, 16'h0888, 1);
        chk("rf_valid", out_valid, 0);
        chk("rf_occ", occupancy, 0);
        chk("rf_stall", stall_count, 0);
        chk("rf_data", out_data, 0);

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)),
                $urandom_range(0, 2) != 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
